pipe_stage_buffer: RTL and testbench
====================================

Name: pipe_stage_buffer

Overview:
Parametrised elastic pipeline-stage register, the successor to the fixed two-word IF/ID latch. It carries FIELDS words of WIDTH bits each, for example PC and instruction. Transfers use a valid/ready handshake, with a two-entry skid so backpressure never drops data. It also supports synchronous flush with bubble insertion and a saturating stall counter. One instance sits between each pair of pipeline stages (IF/ID, ID/EX, ...).

Parameters:
WIDTH, 16, bits per field
FIELDS, 2, number of fields carried per entry
BUBBLE, 16'h0000, per-field value presented on OUT_DATA when no valid entry is held (NOP encoding)
CNT_W, 8, width of stall counter

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  synchronous active-low reset
FLUSH  input  1  synchronous flush: discard all held and incoming data
IN_VALID  input  1  upstream has an entry on IN_DATA
IN_READY  output  1  buffer can accept an entry this cycle
IN_DATA  input  FIELDS*WIDTH  packed fields, field k at bits [k*WIDTH +: WIDTH]
OUT_VALID  output  1  OUT_DATA holds a valid entry
OUT_READY  input  1  downstream accepts OUT_DATA this cycle
OUT_DATA  output  FIELDS*WIDTH  registered head entry; bubble pattern when OUT_VALID=0
OCCUPANCY  output  2  number of entries held (0..2)
STALL_COUNT  output  CNT_W  saturating count of cycles with OUT_VALID=1 and OUT_READY=0

Behaviour:
- Clock and reset: one clock CLK. RST is synchronous and active-low; it is sampled only on the rising edge of CLK.
- Reset (RST=0 at posedge):
  - state EMPTY, OUT_VALID=0, OUT_DATA={FIELDS{BUBBLE}}, OCCUPANCY=0, STALL_COUNT=0.
  - IN_READY=0 while RST=0; IN_READY=1 in the first cycle after RST returns to 1.
  - Reset overrides FLUSH and all handshakes.
- Handshakes:
  - Input accept = IN_VALID & IN_READY at posedge.
  - Output accept = OUT_VALID & OUT_READY at posedge.
  - IN_READY is registered, equals !(state==FULL), and does not depend combinationally on OUT_READY.
- Storage: main register (drives OUT_DATA directly) plus skid register. Order is strictly FIFO.
- States (OCCUPANCY mirrors them):
  - EMPTY (0): input accept -> main<=IN_DATA, go ONE. Latency from accept to OUT_VALID is 1 cycle.
  - ONE (1), transitions by accept combination:
    - Output accept, no input accept -> go EMPTY, OUT_DATA<=bubble.
    - Input and output accept -> main<=IN_DATA, stay ONE. Full throughput, no bubble.
    - Input accept, no output accept -> skid<=IN_DATA, go FULL.
  - FULL (2): IN_READY=0, no input accepted. Output accept -> main<=skid, go ONE.
- FLUSH=1 at posedge (RST=1):
  - Clear both entries, go EMPTY, OUT_VALID=0, OUT_DATA<=bubble, IN_READY<=1.
  - Any input accept in the same cycle is dropped. Any output accept in the same cycle counts as consumed downstream; the buffer does not care.
- STALL_COUNT:
  - Increments by 1 each cycle with OUT_VALID=1 and OUT_READY=0.
  - Saturates at 2^CNT_W-1, never wraps.
  - Cleared only by reset, not by FLUSH.
- OUT_DATA: changes only on posedge; it is stable while OUT_VALID=1 and OUT_READY=0.
- Unused: IN_DATA is ignored when IN_VALID=0; OUT_READY is ignored when OUT_VALID=0.
- No combinational path from any input to any output.

Test Plan:
- Reset, then stream A,B,C with IN_VALID=1 and OUT_READY=1 constantly -> OUT_VALID rises 1 cycle after A accepted; A,B,C appear on consecutive cycles; OCCUPANCY stays 1; STALL_COUNT=0.
- Send A,B with OUT_READY=0 -> OCCUPANCY=2, IN_READY=0, OUT_DATA=A held stable. Raise OUT_READY -> A then B delivered in order, IN_READY returns 1 the cycle after A leaves, with no loss or duplication.
- Hold OUT_VALID=1 and OUT_READY=0 for 300 cycles with CNT_W=8 -> STALL_COUNT reaches 255 and stays 255.
- FULL state (A,B held), assert FLUSH with IN_VALID=1 and data C -> next cycle OUT_VALID=0, OUT_DATA=bubble, OCCUPANCY=0, IN_READY=1; C is never output.
- Assert RST=0 mid-stream with FLUSH=1 simultaneously -> at the next posedge all outputs take reset values, IN_READY=0 during reset, STALL_COUNT=0. Release -> IN_READY=1 the next cycle.
- FIELDS=3, WIDTH=8, BUBBLE=8'hFF: push {8'h03,8'h02,8'h01} -> field0=01, field1=02, field2=03 on OUT_DATA; when idle, OUT_DATA=24'hFFFFFF.

Source files
------------

// File: rtl/pipe_stage_buffer_if.sv
// Handshake bundle for one elastic pipeline stage.
// master = upstream/downstream environment, slave = the buffer itself.
interface pipe_stage_buffer_if #(
   parameter int WIDTH  = 16,
   parameter int FIELDS = 2,
   parameter int CNT_W  = 8
);
   logic                      FLUSH;
   logic                      IN_VALID;
   logic                      IN_READY;
   logic [FIELDS*WIDTH-1:0]   IN_DATA;
   logic                      OUT_VALID;
   logic                      OUT_READY;
   logic [FIELDS*WIDTH-1:0]   OUT_DATA;
   logic [1:0]                OCCUPANCY;
   logic [CNT_W-1:0]          STALL_COUNT;

   modport master (
      output FLUSH, IN_VALID, IN_DATA, OUT_READY,
      input  IN_READY, OUT_VALID, OUT_DATA, OCCUPANCY, STALL_COUNT
   );

   modport slave (
      input  FLUSH, IN_VALID, IN_DATA, OUT_READY,
      output IN_READY, OUT_VALID, OUT_DATA, OCCUPANCY, STALL_COUNT
   );
endinterface

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline-stage register: main + skid entry, valid/ready handshake,
// flush with bubble insertion and a saturating stall counter. All outputs registered.
module pipe_stage_buffer #(
   parameter int               WIDTH  = 16,
   parameter int               FIELDS = 2,
   parameter logic [WIDTH-1:0] BUBBLE = 16'h0000,
   parameter int               CNT_W  = 8
) (
   input  logic               CLK,
   input  logic               RST,
   pipe_stage_buffer_if.slave bus
);
   localparam int DW = FIELDS * WIDTH;
   localparam logic [CNT_W-1:0] STALL_MAX = '1;
   localparam logic [CNT_W-1:0] STALL_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t           state_q;
   logic [DW-1:0]    main_q;
   logic [DW-1:0]    skid_q;
   logic             out_valid_q;
   logic             in_ready_q;
   logic [1:0]       occ_q;
   logic [CNT_W-1:0] stall_q;
   logic [DW-1:0]    bubble_word;
   logic             in_acc;
   logic             out_acc;

   for (genvar gi = 0; gi < FIELDS; gi++) begin : g_bubble
      assign bubble_word[gi*WIDTH +: WIDTH] = BUBBLE;
   end

   assign in_acc  = bus.IN_VALID & in_ready_q;
   assign out_acc = out_valid_q & bus.OUT_READY;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q     <= S_EMPTY;
         main_q      <= bubble_word;
         skid_q      <= bubble_word;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         occ_q       <= 2'd0;
         stall_q     <= '0;
      end else begin
         // Counts regardless of flush; only reset clears it.
         if (out_valid_q && !bus.OUT_READY && stall_q != STALL_MAX)
            stall_q <= stall_q + STALL_ONE;

         if (bus.FLUSH) begin
            state_q     <= S_EMPTY;
            main_q      <= bubble_word;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occ_q       <= 2'd0;
         end else begin
            case (state_q)
               S_EMPTY: begin
                  in_ready_q <= 1'b1;
                  if (in_acc) begin
                     main_q      <= bus.IN_DATA;
                     out_valid_q <= 1'b1;
                     occ_q       <= 2'd1;
                     state_q     <= S_ONE;
                  end
               end
               S_ONE: begin
                  in_ready_q <= 1'b1;
                  if (out_acc && !in_acc) begin
                     main_q      <= bubble_word;
                     out_valid_q <= 1'b0;
                     occ_q       <= 2'd0;
                     state_q     <= S_EMPTY;
                  end else if (out_acc && in_acc) begin
                     main_q <= bus.IN_DATA;
                  end else if (in_acc) begin
                     skid_q     <= bus.IN_DATA;
                     in_ready_q <= 1'b0;
                     occ_q      <= 2'd2;
                     state_q    <= S_FULL;
                  end
               end
               S_FULL: begin
                  if (out_acc) begin
                     main_q     <= skid_q;
                     in_ready_q <= 1'b1;
                     occ_q      <= 2'd1;
                     state_q    <= S_ONE;
                  end
               end
               default: begin
                  main_q      <= bubble_word;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  occ_q       <= 2'd0;
                  state_q     <= S_EMPTY;
               end
            endcase
         end
      end
   end

   assign bus.IN_READY    = in_ready_q;
   assign bus.OUT_VALID   = out_valid_q;
   assign bus.OUT_DATA    = main_q;
   assign bus.OCCUPANCY   = occ_q;
   assign bus.STALL_COUNT = stall_q;
endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Randomised + directed bench for pipe_stage_buffer against a queue-based reference model,
// plus a short check of a 3-field / 8-bit / 8'hFF-bubble instance.
module tb_pipe_stage_buffer;
   localparam int W  = 16;
   localparam int F  = 2;
   localparam int CW = 8;
   localparam int DW = W * F;
   localparam int STALL_CAP = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst3_n = 1'b0;
   always #5 clk = ~clk;

   pipe_stage_buffer_if #(.WIDTH(W), .FIELDS(F), .CNT_W(CW)) bus ();
   pipe_stage_buffer #(.WIDTH(W), .FIELDS(F), .BUBBLE(16'h0000), .CNT_W(CW)) dut (
      .CLK(clk), .RST(rst_n), .bus(bus)
   );

   pipe_stage_buffer_if #(.WIDTH(8), .FIELDS(3), .CNT_W(8)) bus3 ();
   pipe_stage_buffer #(.WIDTH(8), .FIELDS(3), .BUBBLE(8'hFF), .CNT_W(8)) dut3 (
      .CLK(clk), .RST(rst3_n), .bus(bus3)
   );

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: a FIFO of held entries, registered ready, stall counter.
   logic [DW-1:0] mq[$];
   logic          m_in_ready = 1'b0;
   int            m_stall = 0;
   logic [DW-1:0] nd = 32'hA000_0001;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic cycle(input logic r, input logic f, input logic iv,
                        input logic [DW-1:0] d, input logic ordy);
      logic oacc;
      logic iacc;
      logic [DW-1:0] exp_data;
      rst_n         = r;
      bus.FLUSH     = f;
      bus.IN_VALID  = iv;
      bus.IN_DATA   = d;
      bus.OUT_READY = ordy;
      @(posedge clk);
      if (!r) begin
         mq.delete();
         m_in_ready = 1'b0;
         m_stall    = 0;
      end else begin
         if (mq.size() > 0 && !ordy && m_stall < STALL_CAP) m_stall++;
         oacc = (mq.size() > 0) && ordy;
         iacc = iv && m_in_ready;
         if (f) begin
            mq.delete();
         end else begin
            if (oacc) begin
               $display("[TB] t=%0t deliver %08h", $time, mq[0]);
               void'(mq.pop_front());
            end
            if (iacc) mq.push_back(d);
         end
         m_in_ready = (mq.size() < 2);
      end
      #1;
      exp_data = (mq.size() > 0) ? mq[0] : '0;
      check("out_valid", 64'(bus.OUT_VALID), 64'(mq.size() > 0));
      check("out_data",  64'(bus.OUT_DATA),  64'(exp_data));
      check("occupancy", 64'(bus.OCCUPANCY), 64'(mq.size()));
      check("in_ready",  64'(bus.IN_READY),  64'(m_in_ready));
      check("stall_cnt", 64'(bus.STALL_COUNT), 64'(m_stall));
   endtask

   task automatic push(input logic ordy);
      cycle(1'b1, 1'b0, 1'b1, nd, ordy);
      nd = nd + 32'h0001_0003;
   endtask

   initial begin
      logic [23:0] o3;
      bus3.FLUSH = 1'b0; bus3.IN_VALID = 1'b0; bus3.IN_DATA = '0; bus3.OUT_READY = 1'b0;

      // Reset, then stream with no backpressure
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 4; i++) push(1'b1);
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);

      // Backpressure into the skid, then drain in order
      push(1'b0);
      push(1'b0);
      push(1'b0);
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
      check("full_in_ready", 64'(bus.IN_READY), 64'(0));
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);

      // Stall counter saturation
      push(1'b0);
      for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
      check("stall_sat", 64'(bus.STALL_COUNT), 64'(255));
      cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
      check("stall_kept_by_flush", 64'(bus.STALL_COUNT), 64'(255));

      // Flush while full with a simultaneous incoming entry
      push(1'b0);
      push(1'b0);
      cycle(1'b1, 1'b1, 1'b1, 32'hC0C0_C0C0, 1'b0);
      for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);

      // Reset with flush mid-stream
      push(1'b0);
      push(1'b1);
      cycle(1'b0, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
      cycle(1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
      check("in_ready_after_rst", 64'(bus.IN_READY), 64'(1));

      // Random traffic with varying backpressure
      for (int i = 0; i < 600; i++) begin
         logic r, f, iv, ordy;
         r    = ($urandom_range(0, 79) != 0);
         f    = ($urandom_range(0, 19) == 0);
         iv   = ($urandom_range(0, 3) != 0);
         ordy = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         cycle(r, f, iv, DW'($urandom), ordy);
      end

      // Three 8-bit fields with 8'hFF bubble
      rst3_n = 1'b0;
      @(posedge clk); #1;
      check("f3_rst_valid", 64'(bus3.OUT_VALID), 64'(0));
      check("f3_rst_data",  64'(bus3.OUT_DATA),  64'h00FF_FFFF);
      rst3_n = 1'b1;
      @(posedge clk); #1;
      check("f3_in_ready", 64'(bus3.IN_READY), 64'(1));
      bus3.IN_VALID = 1'b1; bus3.IN_DATA = 24'h030201;
      @(posedge clk); #1;
      bus3.IN_VALID = 1'b0; bus3.IN_DATA = 24'h0;
      o3 = bus3.OUT_DATA;
      check("f3_valid",  64'(bus3.OUT_VALID), 64'(1));
      check("f3_field0", 64'(o3[7:0]),   64'h01);
      check("f3_field1", 64'(o3[15:8]),  64'h02);
      check("f3_field2", 64'(o3[23:16]), 64'h03);
      $display("[TB] t=%0t f3 deliver %06h", $time, o3);
      bus3.OUT_READY = 1'b1;
      @(posedge clk); #1;
      check("f3_idle_valid", 64'(bus3.OUT_VALID), 64'(0));
      check("f3_idle_data",  64'(bus3.OUT_DATA),  64'h00FF_FFFF);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
